// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, nibble width and saturation limits.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLE_W = 4;

    // Largest positive two's-complement value for a w-bit word (w <= 64).
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value for a w-bit word (w <= 64).
    function automatic logic [63:0] sat_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// Combinational 4-bit carry-lookahead adder with carry-out and signed-overflow flags.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       ovfl
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & cin);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ {c3, c2, c1, cin};
        cout = c4;
        ovfl = c4 ^ c3;
    end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle add/subtract: one nibble per cycle through a single cla_4bit,
// carry chained through a register, valid/ready on both sides.
module nibble_serial_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NIBBLES - 1);
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    state_t               state;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic                 carry;
    logic                 sat_r;
    logic [IDX_W-1:0]     idx;
    logic [WIDTH-1:0]     res;
    logic                 cout_r;
    logic                 ovfl_r;
    logic                 zero_r;
    logic                 neg_r;

    logic [NIBBLE_W-1:0]  nib_a;
    logic [NIBBLE_W-1:0]  nib_b;
    logic [NIBBLE_W-1:0]  nib_sum;
    logic                 nib_cout;
    logic                 nib_ovfl;
    logic [WIDTH-1:0]     res_nx;
    logic [WIDTH-1:0]     final_res;

    always_comb begin
        nib_a = opa[idx*NIBBLE_W +: NIBBLE_W];
        nib_b = opb[idx*NIBBLE_W +: NIBBLE_W];
    end

    cla_4bit u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout),
        .ovfl (nib_ovfl)
    );

    // final_res is only consumed on the last nibble, where nib_ovfl is the word overflow.
    always_comb begin
        res_nx = res;
        res_nx[idx*NIBBLE_W +: NIBBLE_W] = nib_sum;
        final_res = res_nx;
        if (sat_r && nib_ovfl) begin
            final_res = opa[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            sat_r  <= 1'b0;
            idx    <= '0;
            res    <= '0;
            cout_r <= 1'b0;
            ovfl_r <= 1'b0;
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub;
                        sat_r <= sat;
                        idx   <= '0;
                        res   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= nib_cout;
                    if (idx == LAST) begin
                        res    <= final_res;
                        cout_r <= nib_cout;
                        ovfl_r <= nib_ovfl;
                        zero_r <= (final_res == '0);
                        neg_r  <= final_res[WIDTH-1];
                        state  <= DONE;
                    end else begin
                        res <= res_nx;
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res;
    assign cout      = cout_r;
    assign ovfl      = ovfl_r;
    assign zero      = zero_r;
    assign neg       = neg_r;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed scoreboard bench for nibble_serial_addsub at WIDTH=16.
module tb_nibble_serial_addsub;

    localparam int unsigned W       = 16;
    localparam int unsigned NIBBLES = W / 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          sat;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          cout;
    logic          ovfl;
    logic          zero;
    logic          neg;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    nibble_serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovfl      (ovfl),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic t);
        logic [W-1:0] yy;
        logic [W:0]   full;
        exp_t         e;
        yy    = s ? ~y : y;
        full  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
        e.c   = full[W];
        e.v   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        e.res = full[W-1:0];
        if (t && e.v) e.res = x[W-1] ? 16'h8000 : 16'h7FFF;
        e.z   = (e.res == '0);
        e.n   = e.res[W-1];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at posedge+1 with the unit idle; returns at posedge+1 after the accept edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic t);
        chk("in_ready_before_send", 32'(in_ready), 32'd1);
        a = x; b = y; sub = s; sat = t; in_valid = 1'b1;
        sbq.push_back(model(x, y, s, t));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom(); b = $urandom(); sub = $urandom(); sat = $urandom();
    endtask

    task automatic wait_check(input bit chk_lat);
        int   edges;
        exp_t e;
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        if (chk_lat) chk("latency", 32'(edges), 32'(NIBBLES));
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("cout",   32'(cout),   32'(e.c));
            chk("ovfl",   32'(ovfl),   32'(e.v));
            chk("zero",   32'(zero),   32'(e.z));
            chk("neg",    32'(neg),    32'(e.n));
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_idle",  32'(in_ready),  32'd1);
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic s, input logic t);
        send(x, y, s, t);
        wait_check(1'b1);
        release_out();
    endtask

    initial begin
        logic [W-1:0] held_res;
        logic [4:0]   held_flags;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; sat = 1'b0;
        #3;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_flags",     32'({cout, ovfl, zero, neg}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        op(16'h1234, 16'h4321, 1'b0, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        op(16'h0005, 16'h0005, 1'b1, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op(16'h8000, 16'h0001, 1'b1, 1'b0);
        op(16'h8000, 16'h0001, 1'b1, 1'b1);

        // Backpressure: result held while new operands are offered in DONE.
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        wait_check(1'b1);
        held_res   = result;
        held_flags = {out_valid, cout, ovfl, zero, neg};
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; sat = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_result",   32'(result), 32'(held_res));
            chk("bp_flags",    32'({out_valid, cout, ovfl, zero, neg}), 32'(held_flags));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_out();
        op(16'h1111, 16'h2222, 1'b0, 1'b0);

        // Asynchronous reset while the third nibble is being processed.
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result",    32'(result),    32'd0);
        chk("arst_flags",     32'({cout, ovfl, zero, neg}), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("arst_hold_out_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        op(16'h00FF, 16'h0001, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
Multi-cycle WIDTH-bit add/subtract unit that feeds operands one nibble per cycle into a single cla_4bit instance and chains the carry through a register. It sits between the ALU operand muxes and the result/flag writeback. It trades latency for area, uses a valid/ready handshake on both sides, and produces sum, carry, overflow, zero and negative flags, with optional signed saturation.

Parameters:
WIDTH, 16, operand/result width; multiple of 4, minimum 8
NIBBLES, WIDTH/4, derived localparam giving the cycle count of the RUN phase

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands a, b, sub, sat valid
in_ready  out  1  unit can accept operands
a  in  WIDTH  operand A (two's complement or unsigned)
b  in  WIDTH  operand B
sub  in  1  1 = A-B, 0 = A+B
sat  in  1  1 = clamp signed overflow
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  final (possibly saturated) sum
cout  out  1  unsigned carry out of MSB; for sub, 1 = no borrow
ovfl  out  1  signed overflow (raw, before saturation)
zero  out  1  result == 0 (post-saturation)
neg  out  1  result[WIDTH-1] (post-saturation)

Behaviour:
- Reset (rst_n low, asynchronous) puts state in IDLE and clears all registers. Outputs during and after reset: in_ready=1; out_valid, result, cout, ovfl, zero, neg all 0. An operation in flight is discarded and no partial result is ever presented.
- States:
  - IDLE: in_ready=1. When in_valid is high, capture opA=a, opB=(sub ? ~b : b), carry=sub, sat_r=sat, idx=0, clear the result register, then go to RUN.
  - RUN: in_ready=0. Drive the cla_4bit with opA/opB nibble[idx] and carry. On each edge, write the Sum into result nibble[idx] and load carry with Cout.
    - When idx==NIBBLES-1, also capture cout=Cout and ovfl=Ovfl, apply saturation and flags, and go to DONE.
    - Otherwise idx increments.
  - DONE: out_valid=1 and in_ready=0. Outputs are held stable. When out_ready is high, go to IDLE on that edge; out_valid drops the next cycle.
- Latency: for an accept edge T0, out_valid is high after edge T0+NIBBLES (4 cycles at WIDTH=16). Minimum initiation interval is NIBBLES+2 cycles with out_ready tied high.
- in_valid in RUN or DONE is ignored. No operands are captured.
- Saturation: if sat_r and ovfl, result = opA[WIDTH-1] ? {1,0...0} : {0,1...1}. The sign is taken from the captured opA. cout and ovfl keep their raw values.
- zero and neg are computed from the final result register and are valid whenever out_valid is high.
- Wrap-around without sat: result is the modulo 2^WIDTH sum, e.g. FFFF+0001 = 0000 with cout=1.
- result/flags hold their last values in IDLE. They are meaningful only while out_valid is high.
- idx width is clog2(NIBBLES). idx never exceeds NIBBLES-1.

Decomposition:
- Shared package alu_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the NIBBLE_W=4 constant;
  - the saturation constants SAT_MAX/SAT_MIN as functions of WIDTH.
- One sub-module: the existing cla_4bit, instantiated once, combinational, fed from the nibble muxes.
- Nibble select and result nibble write stay inline.

Test Plan:
- 0x1234 + 0x4321, sub=0, sat=0 -> result 0x5555, cout=0, ovfl=0, zero=0, neg=0; out_valid exactly 4 cycles after accept.
- 0x7FFF + 0x0001: sat=0 -> 0x8000, ovfl=1, neg=1; repeated with sat=1 -> 0x7FFF, ovfl=1, neg=0.
- sub 0x0005 - 0x0005 -> 0x0000, zero=1, cout=1, ovfl=0; 0xFFFF + 0x0001 -> 0x0000, cout=1, zero=1, ovfl=0.
- sub 0x8000 - 0x0001: sat=0 -> 0x7FFF, ovfl=1; sat=1 -> 0x8000, ovfl=1, neg=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands -> result/flags stable, in_ready=0, new operands not captured. Then out_ready=1 -> IDLE, next op accepted and computed correctly.
- Assert rst_n low during RUN at idx=2 -> outputs go to 0 and in_ready=1 immediately (asynchronously). After release, 0x00FF + 0x0001 -> 0x0100 with normal latency.
